// File: rtl/scpad_pkg.sv
// Shared types for the scratchpad bank sequencer: row/element widths, FSM
// state encoding, request FIFO entry and a saturating counter helper.
package scpad_pkg;

  localparam int ROW_IDX_WIDTH = 6;
  localparam int ELEM_BITS     = 16;
  localparam int PERF_W        = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_RD = 2'd1,
    ST_WAIT_WR = 2'd2,
    ST_RESP    = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic                     write;
    logic [ROW_IDX_WIDTH-1:0] addr;
    logic [ELEM_BITS-1:0]     wdata;
  } req_entry_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v, input logic en);
    if (en && (v != {PERF_W{1'b1}})) begin
      sat_inc = v + 32'd1;
    end else begin
      sat_inc = v;
    end
  endfunction

endpackage

// File: rtl/scpad_sync_fifo.sv
// In-order synchronous FIFO with wrap-bit pointers; a push is honoured
// while full only when a pop frees the head slot in the same cycle.
module scpad_sync_fifo
  import scpad_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = req_entry_t
) (
  input  logic   clk,
  input  logic   n_rst,
  input  logic   push,
  input  entry_t din,
  input  logic   pop,
  output entry_t dout,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  entry_t      mem_q [DEPTH];
  logic        push_ok_s;
  logic        pop_ok_s;

  assign empty     = (wptr_q == rptr_q);
  assign full      = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  assign pop_ok_s  = pop && !empty;
  assign push_ok_s = push && (!full || pop_ok_s);
  assign dout      = mem_q[rptr_q[AW-1:0]];

  // Next-pointer computation.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_ok_s) begin
      wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_ok_s) begin
      rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      rptr_d = rptr_q;
    end
  end

  // Pointer state.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr_q <= {(AW+1){1'b0}};
      rptr_q <= {(AW+1){1'b0}};
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wptr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/scpad_bank_seq.sv
// Scratchpad bank sequencer: queues requests, issues one bank op at a time,
// returns responses in order. Optional counters under SCPAD_BANK_SEQ_PERF_EN.
module scpad_bank_seq
  import scpad_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [ROW_IDX_WIDTH-1:0] req_addr,
  input  logic [ELEM_BITS-1:0]     req_wdata,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic                     resp_write,
  output logic [ELEM_BITS-1:0]     resp_rdata,
  input  logic                     bank_busy,
  output logic                     bank_ren,
  output logic [ROW_IDX_WIDTH-1:0] bank_raddr,
  input  logic [ELEM_BITS-1:0]     bank_rdata,
  input  logic                     bank_rdone,
  output logic                     bank_wen,
  output logic [ROW_IDX_WIDTH-1:0] bank_waddr,
  output logic [ELEM_BITS-1:0]     bank_wdata,
  input  logic                     bank_wdone
`ifdef SCPAD_BANK_SEQ_PERF_EN
  ,
  output logic [PERF_W-1:0]        perf_issue_cnt,
  output logic [PERF_W-1:0]        perf_stall_cnt
`endif
);

  seq_state_e               state_q, state_d;
  logic                     resp_valid_q, resp_valid_d;
  logic                     resp_write_q, resp_write_d;
  logic [ELEM_BITS-1:0]     resp_rdata_q, resp_rdata_d;
  logic                     bank_ren_q, bank_ren_d;
  logic                     bank_wen_q, bank_wen_d;
  logic [ROW_IDX_WIDTH-1:0] bank_raddr_q, bank_raddr_d;
  logic [ROW_IDX_WIDTH-1:0] bank_waddr_q, bank_waddr_d;
  logic [ELEM_BITS-1:0]     bank_wdata_q, bank_wdata_d;

  logic       push_s;
  logic       pop_s;
  logic       full_s;
  logic       empty_s;
  req_entry_t req_entry_s;
  req_entry_t head_s;

  assign req_ready   = !full_s;
  assign push_s      = req_valid && !full_s;
  assign req_entry_s = '{write: req_write, addr: req_addr, wdata: req_wdata};

  scpad_sync_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (req_entry_t)
  ) u_req_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (push_s),
    .din   (req_entry_s),
    .pop   (pop_s),
    .dout  (head_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Sequencer: the issue strobe is a one-cycle pulse; address/data hold afterwards.
  always_comb begin
    state_d      = state_q;
    resp_valid_d = resp_valid_q;
    resp_write_d = resp_write_q;
    resp_rdata_d = resp_rdata_q;
    bank_ren_d   = 1'b0;
    bank_wen_d   = 1'b0;
    bank_raddr_d = bank_raddr_q;
    bank_waddr_d = bank_waddr_q;
    bank_wdata_d = bank_wdata_q;
    pop_s        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty_s && !bank_busy) begin
          pop_s = 1'b1;
          if (head_s.write) begin
            bank_wen_d   = 1'b1;
            bank_waddr_d = head_s.addr;
            bank_wdata_d = head_s.wdata;
            state_d      = ST_WAIT_WR;
          end else begin
            bank_ren_d   = 1'b1;
            bank_raddr_d = head_s.addr;
            state_d      = ST_WAIT_RD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_RD: begin
        if (bank_rdone) begin
          resp_rdata_d = bank_rdata;
          resp_write_d = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = ST_RESP;
        end else begin
          state_d = ST_WAIT_RD;
        end
      end
      ST_WAIT_WR: begin
        if (bank_wdone) begin
          resp_rdata_d = {ELEM_BITS{1'b0}};
          resp_write_d = 1'b1;
          resp_valid_d = 1'b1;
          state_d      = ST_RESP;
        end else begin
          state_d = ST_WAIT_WR;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        resp_valid_d = 1'b0;
        state_d      = ST_IDLE;
      end
    endcase
  end

  // Sequencer and output registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= ST_IDLE;
      resp_valid_q <= 1'b0;
      resp_write_q <= 1'b0;
      resp_rdata_q <= {ELEM_BITS{1'b0}};
      bank_ren_q   <= 1'b0;
      bank_wen_q   <= 1'b0;
      bank_raddr_q <= {ROW_IDX_WIDTH{1'b0}};
      bank_waddr_q <= {ROW_IDX_WIDTH{1'b0}};
      bank_wdata_q <= {ELEM_BITS{1'b0}};
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_write_q <= resp_write_d;
      resp_rdata_q <= resp_rdata_d;
      bank_ren_q   <= bank_ren_d;
      bank_wen_q   <= bank_wen_d;
      bank_raddr_q <= bank_raddr_d;
      bank_waddr_q <= bank_waddr_d;
      bank_wdata_q <= bank_wdata_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_write = resp_write_q;
  assign resp_rdata = resp_rdata_q;
  assign bank_ren   = bank_ren_q;
  assign bank_wen   = bank_wen_q;
  assign bank_raddr = bank_raddr_q;
  assign bank_waddr = bank_waddr_q;
  assign bank_wdata = bank_wdata_q;

`ifdef SCPAD_BANK_SEQ_PERF_EN
  logic              stall_s;
  logic [PERF_W-1:0] perf_issue_q, perf_issue_d;
  logic [PERF_W-1:0] perf_stall_q, perf_stall_d;

  // A stall is a cycle where work is queued but the bank refuses it.
  always_comb begin
    stall_s      = (state_q == ST_IDLE) && !empty_s && bank_busy;
    perf_issue_d = sat_inc(perf_issue_q, pop_s);
    perf_stall_d = sat_inc(perf_stall_q, stall_s);
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      perf_issue_q <= {PERF_W{1'b0}};
      perf_stall_q <= {PERF_W{1'b0}};
    end else begin
      perf_issue_q <= perf_issue_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_issue_cnt = perf_issue_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_scpad_bank_seq.sv
// Directed bench for scpad_bank_seq with a behavioural bank of configurable
// read/write latency and an in-order response scoreboard.
module tb_scpad_bank_seq;
  import scpad_pkg::*;

  localparam int DEPTH = 4;

  logic                     clk;
  logic                     n_rst;
  logic                     req_valid, req_ready, req_write;
  logic [ROW_IDX_WIDTH-1:0] req_addr;
  logic [ELEM_BITS-1:0]     req_wdata;
  logic                     resp_valid, resp_ready, resp_write;
  logic [ELEM_BITS-1:0]     resp_rdata;
  logic                     bank_busy, bank_ren, bank_rdone, bank_wen, bank_wdone;
  logic [ROW_IDX_WIDTH-1:0] bank_raddr, bank_waddr;
  logic [ELEM_BITS-1:0]     bank_rdata, bank_wdata;
`ifdef SCPAD_BANK_SEQ_PERF_EN
  logic [31:0]              perf_issue_cnt, perf_stall_cnt;
`endif

  scpad_bank_seq #(.DEPTH(DEPTH)) dut (
    .clk(clk), .n_rst(n_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_write(resp_write),
    .resp_rdata(resp_rdata),
    .bank_busy(bank_busy), .bank_ren(bank_ren), .bank_raddr(bank_raddr),
    .bank_rdata(bank_rdata), .bank_rdone(bank_rdone),
    .bank_wen(bank_wen), .bank_waddr(bank_waddr), .bank_wdata(bank_wdata),
    .bank_wdone(bank_wdone)
`ifdef SCPAD_BANK_SEQ_PERF_EN
    , .perf_issue_cnt(perf_issue_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Bank model knobs (written only by the main process).
  int  rd_lat = 2;
  int  wr_lat = 2;
  bit  spur_wdone = 1'b0;
  int  spur_req = 0;
  int  spur_done = 0;
  logic [ELEM_BITS-1:0] bank_mem [64];

  // Behavioural bank: done arrives rd_lat/wr_lat cycles after the issue cycle.
  initial begin
    logic [ROW_IDX_WIDTH-1:0] a;
    bank_rdone = 1'b0;
    bank_wdone = 1'b0;
    bank_rdata = 16'h0000;
    for (int i = 0; i < 64; i++) bank_mem[i] = 16'h0000;
    forever begin
      @(posedge clk); #1;
      if (bank_ren) begin
        a = bank_raddr;
        if (spur_wdone) begin
          @(posedge clk); #1 bank_wdone = 1'b1;
          @(posedge clk); #1 bank_wdone = 1'b0;
          repeat (rd_lat - 2) @(posedge clk);
        end else begin
          repeat (rd_lat) @(posedge clk);
        end
        #1;
        bank_rdata = bank_mem[a];
        bank_rdone = 1'b1;
        @(posedge clk); #1;
        bank_rdone = 1'b0;
        bank_rdata = 16'hFFFF;
      end else if (bank_wen) begin
        bank_mem[bank_waddr] = bank_wdata;
        repeat (wr_lat) @(posedge clk);
        #1 bank_wdone = 1'b1;
        @(posedge clk); #1 bank_wdone = 1'b0;
      end else if (spur_req != spur_done) begin
        bank_rdone = 1'b1;
        bank_wdone = 1'b1;
        bank_rdata = 16'hBEEF;
        @(posedge clk); #1;
        bank_rdone = 1'b0;
        bank_wdone = 1'b0;
        spur_done++;
      end
    end
  end

  // Monitor: issue counts, issue spacing, latency and observed responses.
  int   cyc = 0, issue_cyc = 0, lat_cur = 0;
  int   ren_cnt = 0, wen_cnt = 0, viol = 0, resp_cnt = 0;
  logic prev_issue = 1'b0, prev_rv = 1'b0;
  logic                 obs_w   [64];
  logic [ELEM_BITS-1:0] obs_d   [64];
  int                   obs_lat [64];
  initial forever begin
    @(negedge clk);
    cyc++;
    if (bank_ren && bank_wen) viol++;
    if ((bank_ren || bank_wen) && prev_issue) viol++;
    if (bank_ren) ren_cnt++;
    if (bank_wen) wen_cnt++;
    if (bank_ren || bank_wen) issue_cyc = cyc;
    if (resp_valid && !prev_rv) lat_cur = cyc - issue_cyc;
    if (resp_valid && resp_ready && resp_cnt < 64) begin
      obs_w[resp_cnt]   = resp_write;
      obs_d[resp_cnt]   = resp_rdata;
      obs_lat[resp_cnt] = lat_cur;
      resp_cnt++;
    end
    prev_issue = bank_ren || bank_wen;
    prev_rv    = resp_valid;
  end

  // Expected responses, hand-listed by each test.
  logic                 exp_w [64];
  logic [ELEM_BITS-1:0] exp_d [64];
  int exp_n = 0;
  int chk_idx = 0;

  task automatic expect_resp(input logic w, input logic [ELEM_BITS-1:0] d);
    exp_w[exp_n] = w;
    exp_d[exp_n] = d;
    exp_n++;
  endtask

  task automatic wait_resps(input int budget);
    int t = 0;
    while (resp_cnt < exp_n && t < budget) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk_eq("resp_count", resp_cnt, exp_n);
    for (int i = chk_idx; i < exp_n && i < resp_cnt; i++) begin
      chk_eq($sformatf("resp%0d_write", i), 32'(obs_w[i]), 32'(exp_w[i]));
      chk_eq($sformatf("resp%0d_rdata", i), 32'(obs_d[i]), 32'(exp_d[i]));
    end
    chk_idx = exp_n;
  endtask

  task automatic push_req(input logic w, input logic [ROW_IDX_WIDTH-1:0] a,
                          input logic [ELEM_BITS-1:0] d);
    int t = 0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    @(negedge clk);
    while (!req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) chk_eq("push_timeout", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  initial begin
    int r0, w0, t;
`ifdef SCPAD_BANK_SEQ_PERF_EN
    logic [31:0] s0, p0;
`endif
    n_rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 6'd0;
    req_wdata = 16'h0000; resp_ready = 1'b0; bank_busy = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk_eq("rst_req_ready",  32'(req_ready),  32'd1);
    chk_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk_eq("rst_bank_ren",   32'(bank_ren),   32'd0);
    chk_eq("rst_bank_wen",   32'(bank_wen),   32'd0);
    chk_eq("rst_resp_rdata", 32'(resp_rdata), 32'd0);
    n_rst = 1'b1;
    @(posedge clk); #1;

    // Write 5 <- A5 then read it back; write latency 4, read latency 2.
    wr_lat = 4; rd_lat = 2; resp_ready = 1'b1;
    r0 = ren_cnt; w0 = wen_cnt;
    push_req(1'b1, 6'd5, 16'h00A5);
    expect_resp(1'b1, 16'h0000);
    wait_resps(50);
    chk_eq("wr_latency", obs_lat[0], 32'd5);
    push_req(1'b0, 6'd5, 16'h0000);
    expect_resp(1'b0, 16'h00A5);
    wait_resps(50);
    chk_eq("rd_latency", obs_lat[1], 32'd3);
    chk_eq("wen_pulses", wen_cnt - w0, 32'd1);
    chk_eq("ren_pulses", ren_cnt - r0, 32'd1);

    // Back-to-back pushes with the response held: FIFO fills, nothing lost.
    wr_lat = 1; rd_lat = 1; resp_ready = 1'b0;
    r0 = ren_cnt; w0 = wen_cnt;
    push_req(1'b1, 6'd10, 16'h1111); expect_resp(1'b1, 16'h0000);
    push_req(1'b1, 6'd11, 16'h2222); expect_resp(1'b1, 16'h0000);
    push_req(1'b0, 6'd10, 16'h0000); expect_resp(1'b0, 16'h1111);
    push_req(1'b0, 6'd11, 16'h0000); expect_resp(1'b0, 16'h2222);
    push_req(1'b1, 6'd12, 16'h3333); expect_resp(1'b1, 16'h0000);
    repeat (8) @(posedge clk); #1;
    chk_eq("full_req_ready",   32'(req_ready),  32'd0);
    chk_eq("held_issue_count", (ren_cnt - r0) + (wen_cnt - w0), 32'd1);
    chk_eq("held_resp_valid",  32'(resp_valid), 32'd1);
    chk_eq("held_resp_write",  32'(resp_write), 32'd1);
    resp_ready = 1'b1;
    wait_resps(100);
    chk_eq("drain_issue_count", (ren_cnt - r0) + (wen_cnt - w0), 32'd5);

    // Bank busy for 10 cycles with a queued read.
    rd_lat = 2; bank_busy = 1'b1;
    r0 = ren_cnt; w0 = wen_cnt;
`ifdef SCPAD_BANK_SEQ_PERF_EN
    s0 = perf_stall_cnt; p0 = perf_issue_cnt;
`endif
    push_req(1'b0, 6'd10, 16'h0000);
    expect_resp(1'b0, 16'h1111);
    repeat (10) @(posedge clk); #1;
    chk_eq("busy_no_issue", (ren_cnt - r0) + (wen_cnt - w0), 32'd0);
`ifdef SCPAD_BANK_SEQ_PERF_EN
    chk_eq("perf_stall_cnt", perf_stall_cnt - s0, 32'd10);
    chk_eq("perf_issue_busy", perf_issue_cnt - p0, 32'd0);
`endif
    bank_busy = 1'b0;
    wait_resps(50);
    chk_eq("busy_then_issue", ren_cnt - r0, 32'd1);

    // Spurious wdone during a read; spurious dones while idle.
    rd_lat = 3; spur_wdone = 1'b1;
    push_req(1'b0, 6'd11, 16'h0000);
    expect_resp(1'b0, 16'h2222);
    wait_resps(50);
    chk_eq("spur_rd_latency", obs_lat[exp_n-1], 32'd4);
    spur_wdone = 1'b0;
    spur_req++;
    repeat (4) @(posedge clk); #1;
    chk_eq("idle_spur_valid", 32'(resp_valid), 32'd0);
    wait_resps(0);

    // Fill the FIFO, then release the response while a push is pending.
    rd_lat = 1; wr_lat = 1; resp_ready = 1'b0;
    r0 = ren_cnt; w0 = wen_cnt;
    push_req(1'b1, 6'd20, 16'h0A0A); expect_resp(1'b1, 16'h0000);
    push_req(1'b0, 6'd20, 16'h0000); expect_resp(1'b0, 16'h0A0A);
    push_req(1'b1, 6'd21, 16'h0B0B); expect_resp(1'b1, 16'h0000);
    push_req(1'b0, 6'd21, 16'h0000); expect_resp(1'b0, 16'h0B0B);
    push_req(1'b0, 6'd10, 16'h0000); expect_resp(1'b0, 16'h1111);
    repeat (6) @(posedge clk); #1;
    chk_eq("wrap_full_ready", 32'(req_ready), 32'd0);
    resp_ready = 1'b1;
    push_req(1'b0, 6'd12, 16'h0000); expect_resp(1'b0, 16'h3333);
    wait_resps(100);
    chk_eq("wrap_issue_count", (ren_cnt - r0) + (wen_cnt - w0), 32'd6);

    // Reset while a read is outstanding; the late rdone must be dropped.
    rd_lat = 8;
    r0 = ren_cnt;
    push_req(1'b0, 6'd20, 16'h0000);
    t = 0;
    while (ren_cnt == r0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk_eq("rst_test_issue", ren_cnt - r0, 32'd1);
    repeat (2) @(posedge clk); #2;
    n_rst = 1'b0;
    #1;
    chk_eq("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
    chk_eq("mid_rst_resp_write", 32'(resp_write), 32'd0);
    chk_eq("mid_rst_resp_rdata", 32'(resp_rdata), 32'd0);
    chk_eq("mid_rst_bank_ren",   32'(bank_ren),   32'd0);
    chk_eq("mid_rst_bank_wen",   32'(bank_wen),   32'd0);
    chk_eq("mid_rst_bank_raddr", 32'(bank_raddr), 32'd0);
    chk_eq("mid_rst_bank_waddr", 32'(bank_waddr), 32'd0);
    chk_eq("mid_rst_bank_wdata", 32'(bank_wdata), 32'd0);
    chk_eq("mid_rst_req_ready",  32'(req_ready),  32'd1);
    @(posedge clk); #1;
    n_rst = 1'b1;
    repeat (15) @(posedge clk); #1;
    chk_eq("late_rdone_valid", 32'(resp_valid), 32'd0);
    wait_resps(0);

    // Normal operation resumes after reset.
    rd_lat = 2;
    push_req(1'b0, 6'd20, 16'h0000);
    expect_resp(1'b0, 16'h0A0A);
    wait_resps(50);

    chk_eq("issue_spacing_viol", viol, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
